// File: rtl/mem_arb.sv
// Two-port SDRAM request arbiter: port 1 has priority, bounded by a starvation
// guard for port 0; forwards one single-word command at a time to sdram_ctl.
module mem_arb #(
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c0_req,
  input  logic                  c1_req,
  input  logic                  c0_we,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c0_done,
  output logic                  c1_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t                state, state_nxt;
  logic                  gnt, gnt_nxt;
  logic [CNT_W-1:0]      starve_cnt, cnt_nxt;
  logic                  pick1;
  logic                  mem_req_nxt, we_nxt, busy_nxt;
  logic                  done0_nxt, done1_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(STARVE_LIMIT)) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    cnt_nxt     = starve_cnt;
    pick1       = 1'b0;
    mem_req_nxt = mem_req;
    we_nxt      = mem_write_en;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    rdata_nxt   = rdata;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (!c0_req) cnt_nxt = '0;
        if (mem_ready && (c0_req || c1_req)) begin
          // Port 1 wins ties unless port 0 has already waited STARVE_LIMIT grants.
          pick1       = c1_req && !(c0_req && starve_cnt == CNT_W'(STARVE_LIMIT));
          gnt_nxt     = pick1;
          we_nxt      = pick1 ? c1_we    : c0_we;
          addr_nxt    = pick1 ? c1_addr  : c0_addr;
          wdata_nxt   = pick1 ? c1_wdata : c0_wdata;
          mem_req_nxt = 1'b1;
          state_nxt   = ISSUE;
          if (!pick1)
            cnt_nxt = '0;
          else if (c0_req)
            cnt_nxt = sat_inc(starve_cnt);
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          if (mem_write_en) begin
            state_nxt = DONE;
            done0_nxt = !gnt;
            done1_nxt = gnt;
          end else begin
            state_nxt = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_rvalid) begin
          rdata_nxt = mem_rdata;
          state_nxt = DONE;
          done0_nxt = !gnt;
          done1_nxt = gnt;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      starve_cnt   <= '0;
      mem_req      <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata        <= '0;
      c0_done      <= 1'b0;
      c1_done      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      gnt          <= gnt_nxt;
      starve_cnt   <= cnt_nxt;
      mem_req      <= mem_req_nxt;
      mem_write_en <= we_nxt;
      mem_addr     <= addr_nxt;
      mem_wdata    <= wdata_nxt;
      rdata        <= rdata_nxt;
      c0_done      <= done0_nxt;
      c1_done      <= done1_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule
